// File: rtl/jk_reg_bank.sv
// Bank of independent JK flip-flops with load/shift/hold modes, a change flag
// and a saturating toggle-event counter; active clock edge is selectable.
module jk_reg_bank #(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit              NEG_EDGE = 1'b1,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             ser_out,
  output logic             changed,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [1:0] MODE_JK    = 2'd0;
  localparam logic [1:0] MODE_LOAD  = 2'd1;
  localparam logic [1:0] MODE_SHIFT = 2'd2;

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH:0]   shift_ext;
  logic [CNT_W-1:0] cnt_nxt;
  logic             changed_nxt;
  logic             toggle_evt;

  // Widening by one bit keeps the shift expression legal when WIDTH is 1.
  assign shift_ext = {q, ser_in};
  assign toggle_evt = en && (mode == MODE_JK) && (|(j & k));

  always_comb begin
    q_nxt       = q;
    cnt_nxt     = toggle_cnt;
    changed_nxt = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK:    q_nxt = (j & ~q) | (~k & q);
        MODE_LOAD:  q_nxt = d;
        MODE_SHIFT: q_nxt = shift_ext[WIDTH-1:0];
        default:    q_nxt = q;
      endcase
      changed_nxt = (q_nxt != q);
      if (cnt_clr)
        cnt_nxt = '0;
      else if (toggle_evt && (toggle_cnt != {CNT_W{1'b1}}))
        cnt_nxt = toggle_cnt + CNT_W'(1);
    end
  end

  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
          q          <= RST_VAL;
          changed    <= 1'b0;
          toggle_cnt <= '0;
        end else begin
          q          <= q_nxt;
          changed    <= changed_nxt;
          toggle_cnt <= cnt_nxt;
        end
      end
    end else begin : g_pos
      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
          q          <= RST_VAL;
          changed    <= 1'b0;
          toggle_cnt <= '0;
        end else begin
          q          <= q_nxt;
          changed    <= changed_nxt;
          toggle_cnt <= cnt_nxt;
        end
      end
    end
  endgenerate

  assign q_n     = ~q;
  assign ser_out = q[WIDTH-1];

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench: a falling-edge bank with a 4-bit counter plus a rising-edge
// bank used only to confirm edge selection.
module tb_jk_reg_bank;

  logic       clk = 1'b1;
  logic       clr_n;
  logic       en, ser_in, cnt_clr;
  logic [1:0] mode;
  logic [7:0] j, k, d;
  logic [7:0] q, q_n;
  logic       ser_out, changed;
  logic [3:0] toggle_cnt;

  logic        en1, ser_in1, cnt_clr1;
  logic [1:0]  mode1;
  logic [7:0]  j1, k1, d1;
  logic [7:0]  q1, q_n1;
  logic        ser_out1, changed1;
  logic [15:0] toggle_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'h00), .NEG_EDGE(1'b1), .CNT_W(4)) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .ser_in(ser_in), .cnt_clr(cnt_clr), .q(q), .q_n(q_n), .ser_out(ser_out),
    .changed(changed), .toggle_cnt(toggle_cnt)
  );

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'h00), .NEG_EDGE(1'b0), .CNT_W(16)) dut_pos (
    .clk(clk), .clr_n(clr_n), .en(en1), .mode(mode1), .j(j1), .k(k1), .d(d1),
    .ser_in(ser_in1), .cnt_clr(cnt_clr1), .q(q1), .q_n(q_n1), .ser_out(ser_out1),
    .changed(changed1), .toggle_cnt(toggle_cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] jj,
                       input logic [7:0] kk, input logic [7:0] dd, input logic si,
                       input logic cc);
    en = e; mode = m; j = jj; k = kk; d = dd; ser_in = si; cnt_clr = cc;
  endtask

  initial begin
    clr_n = 1'b0;
    drive(1'b1, 2'd1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
    en1 = 1'b0; mode1 = 2'd3; j1 = '0; k1 = '0; d1 = '0; ser_in1 = 1'b0; cnt_clr1 = 1'b0;
    #2;
    chk("rst_q", q, 8'h00);
    chk("rst_qn", q_n, 8'hFF);
    chk("rst_chg", changed, 1'b0);
    chk("rst_cnt", toggle_cnt, 4'h0);
    tick_neg();
    chk("rst_ignores_edge", q, 8'h00);
    clr_n = 1'b1;

    // Build q = 0xA5, toggle_cnt = 5
    drive(1'b1, 2'd0, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick_neg();
    chk("tog5_q", q, 8'h01);
    chk("tog5_cnt", toggle_cnt, 4'h5);
    drive(1'b1, 2'd1, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0);
    tick_neg();
    chk("load_a5", q, 8'hA5);
    chk("load_a5_cnt", toggle_cnt, 4'h5);
    chk("load_a5_chg", changed, 1'b1);
    clr_n = 1'b0;
    #2;
    clr_n = 1'b1;
    #1;
    chk("midrst_q", q, 8'h00);
    chk("midrst_qn", q_n, 8'hFF);
    chk("midrst_chg", changed, 1'b0);
    chk("midrst_cnt", toggle_cnt, 4'h0);

    // JK
    drive(1'b1, 2'd1, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b0);
    tick_neg();
    chk("load_3c", q, 8'h3C);
    drive(1'b1, 2'd0, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0);
    tick_neg();
    chk("jk_set_clr", q, 8'hF0);
    chk("jk_set_clr_chg", changed, 1'b1);
    chk("jk_set_clr_cnt", toggle_cnt, 4'h0);
    drive(1'b1, 2'd0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    tick_neg();
    chk("jk_toggle", q, 8'h0F);
    chk("jk_toggle_cnt", toggle_cnt, 4'h1);
    drive(1'b1, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    tick_neg();
    chk("jk_hold", q, 8'h0F);
    chk("jk_hold_chg", changed, 1'b0);
    chk("jk_hold_cnt", toggle_cnt, 4'h1);
    drive(1'b1, 2'd0, 8'hA0, 8'h0C, 8'h00, 1'b0, 1'b0);
    tick_neg();
    chk("jk_mixed", q, 8'hA3);

    // LOAD / SHIFT / HOLD; j&k set in non-JK modes must not count
    drive(1'b1, 2'd1, 8'hFF, 8'hFF, 8'h5A, 1'b0, 1'b0);
    tick_neg();
    chk("load_5a", q, 8'h5A);
    chk("load_5a_so", ser_out, 1'b0);
    chk("load_nocount", toggle_cnt, 4'h1);
    drive(1'b1, 2'd2, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
    tick_neg();
    chk("shift_b5", q, 8'hB5);
    chk("shift_b5_so", ser_out, 1'b1);
    chk("shift_nocount", toggle_cnt, 4'h1);
    drive(1'b1, 2'd3, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    tick_neg();
    chk("hold_q", q, 8'hB5);
    chk("hold_chg", changed, 1'b0);
    drive(1'b1, 2'd2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    tick_neg();
    chk("shift_6a", q, 8'h6A);
    chk("shift_6a_chg", changed, 1'b1);

    // Enable low freezes everything and ignores cnt_clr
    drive(1'b0, 2'd1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1);
    tick_neg();
    chk("en0_q", q, 8'h6A);
    chk("en0_chg", changed, 1'b0);
    chk("en0_cnt", toggle_cnt, 4'h1);

    // Counter saturation and clear priority
    drive(1'b1, 2'd3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    tick_neg();
    chk("cntclr_hold", toggle_cnt, 4'h0);
    drive(1'b1, 2'd0, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) tick_neg();
    chk("cnt_14", toggle_cnt, 4'hE);
    for (int i = 0; i < 6; i++) tick_neg();
    chk("cnt_sat", toggle_cnt, 4'hF);
    chk("cnt_sat_q", q, 8'h6A);
    drive(1'b1, 2'd0, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1);
    tick_neg();
    chk("cntclr_prio", toggle_cnt, 4'h0);
    chk("cntclr_prio_q", q, 8'h6B);

    // Reset coincident with an active edge wins
    drive(1'b1, 2'd1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk("coinc_rst_q", q, 8'h00);
    chk("coinc_rst_chg", changed, 1'b0);
    #2;
    clr_n = 1'b1;
    tick_neg();
    chk("post_rst_load", q, 8'hFF);

    // Rising-edge instance: falling edge must do nothing
    @(posedge clk);
    #1;
    en1 = 1'b1; mode1 = 2'd1; d1 = 8'h81;
    tick_neg();
    chk("pos_fall_noop", q1, 8'h00);
    @(posedge clk);
    #1;
    chk("pos_rise_load", q1, 8'h81);
    chk("pos_rise_chg", changed1, 1'b1);
    mode1 = 2'd3;
    tick_neg();
    chk("pos_fall_keep_chg", changed1, 1'b1);
    @(posedge clk);
    #1;
    chk("pos_hold_chg", changed1, 1'b0);
    chk("pos_hold_q", q1, 8'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of JK bits in the bank, legal range 1..64.
REQ-002 Parameter RST_VAL, default 0: WIDTH-bit value loaded into q on reset.
REQ-003 Parameter NEG_EDGE, default 1: 1 = state updates on the falling clk edge, 0 = state updates on the rising clk edge.
REQ-004 Parameter CNT_W, default 16: width of toggle_cnt, legal range 2..32.
REQ-005 clk  input  1  clock; its active edge is selected by NEG_EDGE.
REQ-006 clr_n  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  clock enable; 0 freezes all state.
REQ-008 mode  input  2  operation select: 0 = JK, 1 = LOAD, 2 = SHIFT, 3 = HOLD.
REQ-009 j  input  WIDTH  per-bit J inputs, used in JK mode.
REQ-010 k  input  WIDTH  per-bit K inputs, used in JK mode.
REQ-011 d  input  WIDTH  parallel load data, used in LOAD mode.
REQ-012 ser_in  input  1  serial input shifted into bit 0 in SHIFT mode.
REQ-013 cnt_clr  input  1  synchronous clear of toggle_cnt.
REQ-014 q  output  WIDTH  register state.
REQ-015 q_n  output  WIDTH  combinational bitwise inverse of q.
REQ-016 ser_out  output  1  combinational copy of q[WIDTH-1].
REQ-017 changed  output  1  registered flag; high for one clock period after any active edge on which q changed.
REQ-018 toggle_cnt  output  CNT_W  saturating count of toggle events.

Function
REQ-019 All state (q, changed, toggle_cnt) SHALL update only on the active edge selected by NEG_EDGE; the opposite edge SHALL have no effect.
REQ-020 JK mode, per bit i, {j[i],k[i]}: 00 hold; 01 q[i] <= 0; 10 q[i] <= 1; 11 q[i] <= ~q[i]. Bits are fully independent of each other.
REQ-021 LOAD mode: q <= d.
REQ-022 SHIFT mode: q <= {q[WIDTH-2:0], ser_in}. When WIDTH = 1: q <= ser_in.
REQ-023 HOLD mode: q unchanged.
REQ-024 en = 0: q and toggle_cnt hold; changed <= 0. mode, j, k, d, ser_in and cnt_clr are ignored.
REQ-025 changed <= (next q != current q) on every active edge with en = 1.
REQ-026 Toggle event: active edge with en = 1, mode = JK, and (j & k) != 0. toggle_cnt increments by exactly 1 per event, regardless of how many bits toggle.
REQ-027 toggle_cnt saturates at 2^CNT_W-1 and does not wrap; further events leave it unchanged.
REQ-028 cnt_clr = 1 with en = 1: toggle_cnt <= 0 on that edge. cnt_clr has priority over a simultaneous toggle event.
REQ-029 cnt_clr with en = 0: ignored (REQ-024).
REQ-030 Latency: q, changed and toggle_cnt reflect the inputs sampled at the active edge immediately after that edge; no pipeline stages.
REQ-031 q_n and ser_out SHALL be derived combinationally from q, with no additional state.

Reset
REQ-032 clr_n low SHALL immediately, independent of clk, set q = RST_VAL, changed = 0, toggle_cnt = 0.
REQ-033 While clr_n is low, all active edges SHALL be ignored.
REQ-034 Reset asserted mid-operation (including the same instant as an active edge) SHALL win; no partial update survives.
REQ-035 The first active edge after clr_n rises operates normally from the reset state.

Verification (WIDTH=8, RST_VAL=0, NEG_EDGE=1 unless stated)
REQ-036 Reset test: with q = 0xA5 and toggle_cnt = 5, pulse clr_n low between edges -> q = 0x00, q_n = 0xFF, changed = 0, toggle_cnt = 0 before the next edge.
REQ-037 JK test: from q = 0x3C, apply j = 0xF0, k = 0x0F -> q = 0xF0, changed = 1, toggle_cnt = 0. Next edge, j = k = 0xFF -> q = 0x0F, toggle_cnt = 1. Next edge, j = k = 0 -> q = 0x0F, changed = 0.
REQ-038 LOAD/SHIFT test: LOAD d = 0x5A -> q = 0x5A, ser_out = 0. Then SHIFT with ser_in = 1 -> q = 0xB5, ser_out = 1.
REQ-039 Counter test (CNT_W = 4): 20 consecutive toggle events -> toggle_cnt holds at 0xF. Then cnt_clr = 1 together with a toggle event -> toggle_cnt = 0.
REQ-040 Enable test: en = 0, mode = LOAD, d = 0xFF, cnt_clr = 1 -> q, toggle_cnt unchanged, changed = 0.
REQ-041 Edge test (NEG_EDGE = 0): LOAD d = 0x81 -> q updates on the rising edge only; the falling edge produces no change.
